// File: rtl/regacc_pkg.sv
// Shared types and constants for the register file access controller.
// Optional starvation guard is enabled with REGACC_STARVE_GUARD_EN.
package regacc_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      WR_PEND,
      RD_STALL,
      ACK
   } state_t;

   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_ACK   = 1'b0;
   localparam logic   RST_STALL = 1'b0;
   localparam logic   RST_SEL   = 1'b0;

endpackage

// File: rtl/regfile_access_ctrl_wait_ctr.sv
// Saturating wait counter for the debug write starvation guard.
// Only built when REGACC_STARVE_GUARD_EN is defined.
`ifdef REGACC_STARVE_GUARD_EN
module regacc_wait_ctr #(
   parameter int MAX = 8,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic clock,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic reached
);

   localparam logic [CW-1:0] TOP = CW'(MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != TOP) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign reached = (cnt == TOP);

endmodule
`endif

// File: rtl/regfile_access_ctrl.sv
// Arbitrates register file ports between writeback and a debug requester.
// REGACC_STARVE_GUARD_EN adds a bounded wait for pending debug writes.
module regfile_access_ctrl
   import regacc_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_wn,
   input  logic [DW-1:0] pipe_d,
   input  logic          dbg_req,
   input  logic          dbg_wr,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          stall_req,
   output logic          rf_we,
   output logic [AW-1:0] rf_wn,
   output logic [DW-1:0] rf_d,
   output logic          rf_rnb_sel,
   output logic [AW-1:0] rf_rnb,
   input  logic [DW-1:0] rf_qb
);

   state_t        state;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_data;
   logic          rd_stall;
   logic          slot_free;
   logic          starve;
   logic          wr_fire;

   assign slot_free = !pipe_we || (pipe_wn == '0);

`ifdef REGACC_STARVE_GUARD_EN
   logic busy_inc;
   logic ctr_clr;

   assign busy_inc = (state == WR_PEND) && !slot_free && !starve;
   assign ctr_clr  = (state != WR_PEND) || wr_fire;

   regacc_wait_ctr #(
      .MAX(MAX_WAIT)
   ) u_wait (
      .clock  (clock),
      .resetn (resetn),
      .clr    (ctr_clr),
      .inc    (busy_inc),
      .reached(starve)
   );
`else
   // Guard disabled: a pending write waits for a free slot forever.
   assign starve = (MAX_WAIT < 0);
`endif

   // Under a forced stall the pipeline holds off, so the slot is ours.
   assign wr_fire   = (state == WR_PEND) && (slot_free || starve);
   assign stall_req = rd_stall || ((state == WR_PEND) && starve);

   always_comb begin
      rf_we = pipe_we;
      rf_wn = pipe_wn;
      rf_d  = pipe_d;
      if (wr_fire) begin
         rf_we = 1'b1;
         rf_wn = cap_addr;
         rf_d  = cap_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= RST_STATE;
         dbg_ack    <= RST_ACK;
         dbg_rdata  <= '0;
         rd_stall   <= RST_STALL;
         rf_rnb_sel <= RST_SEL;
         rf_rnb     <= '0;
         cap_addr   <= '0;
         cap_data   <= '0;
      end else begin
         dbg_ack    <= 1'b0;
         rd_stall   <= 1'b0;
         rf_rnb_sel <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dbg_req) begin
                  cap_addr <= dbg_addr;
                  cap_data <= dbg_wdata;
                  unique case (1'b1)
                     !dbg_wr: begin
                        state      <= RD_STALL;
                        rd_stall   <= 1'b1;
                        rf_rnb_sel <= 1'b1;
                        rf_rnb     <= dbg_addr;
                     end
                     dbg_wr && (dbg_addr == '0): begin
                        state   <= ACK;
                        dbg_ack <= 1'b1;
                     end
                     dbg_wr && (dbg_addr != '0): begin
                        state <= WR_PEND;
                     end
                  endcase
               end
            end
            WR_PEND: begin
               if (wr_fire) begin
                  state   <= ACK;
                  dbg_ack <= 1'b1;
               end
            end
            RD_STALL: begin
               dbg_rdata <= rf_qb;
               state     <= ACK;
               dbg_ack   <= 1'b1;
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
